// File: rtl/msrv32_pkg.sv
// Shared fetch-path definitions: responder state encoding, the canonical NOP
// word (also used by decode) and the fetch-address fault rule.
// Pure declarations; no logic, no latency, no flow control.
package msrv32_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } imem_state_t;

   // addi x0,x0,0
   localparam logic [31:0] RV_NOP_INSTR = 32'h0000_0013;

   // A fetch faults when it is not word aligned or points past the last
   // stored word (any byte-address bit above the word index is set).
   function automatic logic addr_fault(input logic [31:0] addr,
                                       input int unsigned depth_log2);
      return (addr[1:0] != 2'b00) || ((addr >> (depth_log2 + 2)) != 32'd0);
   endfunction

endpackage

// File: rtl/msrv32_imem_ram.sv
// Instruction storage: 2**DEPTH_LOG2 x 32, one write port, one read port.
// Latency: read data registered one edge after rd_en; read-before-write.
// Backpressure: none; rd_data holds its value while rd_en is low.
//
// Ports: clk; wr_en/wr_addr/wr_data preload write; rd_en/rd_addr read
// strobe and word index; rd_data registered read word. Contents not reset.
module msrv32_imem_ram #(
   parameter int unsigned DEPTH_LOG2 = 10
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [DEPTH_LOG2-1:0] wr_addr,
   input  logic [31:0]           wr_data,
   input  logic                  rd_en,
   input  logic [DEPTH_LOG2-1:0] rd_addr,
   output logic [31:0]           rd_data
);

   logic [31:0] mem [2**DEPTH_LOG2];

   // Both updates are non-blocking on the same edge, so a read of the word
   // being written sees the value from before this edge.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/msrv32_imem_responder.sv
// Instruction-memory responder: one fetch at a time, faults on bad address.
// Latency: accept at cycle N -> instr_valid_out in cycle N+1+WAIT_CYCLES.
// Backpressure: response held until instr_ready_in; flush_in aborts it.
//
// Ports: clk_in, rst_in (async active-low); req_valid_in/req_ready_out/
// i_addr_in fetch request; instr_out/instr_fault_out/instr_valid_out/
// instr_ready_in response; flush_in abort; wr_en_in/wr_addr_in/wr_data_in
// preload write.
module msrv32_imem_responder
   import msrv32_pkg::*;
#(
   parameter int unsigned DEPTH_LOG2  = 10,
   parameter int unsigned WAIT_CYCLES = 1,
   parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  req_valid_in,
   output logic                  req_ready_out,
   input  logic [31:0]           i_addr_in,
   input  logic                  flush_in,
   output logic [31:0]           instr_out,
   output logic                  instr_valid_out,
   input  logic                  instr_ready_in,
   output logic                  instr_fault_out,
   input  logic                  wr_en_in,
   input  logic [DEPTH_LOG2-1:0] wr_addr_in,
   input  logic [31:0]           wr_data_in
);

   localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

   imem_state_t           state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [DEPTH_LOG2-1:0] word_idx_q;
   logic                  pend_fault_q;
   logic                  fault_q;
   logic                  nop_sel_q;
   logic                  accept;
   logic                  rd_en;
   logic                  fault_now;
   logic [DEPTH_LOG2-1:0] rd_idx;
   logic [31:0]           ram_rd_data;

   assign req_ready_out = (state_q == IDLE) && !flush_in;
   assign accept        = req_valid_in && req_ready_out;

   // With zero wait states the read happens on the accept edge itself, so
   // the address and fault come straight from the request port.
   assign rd_idx    = (state_q == IDLE) ? i_addr_in[DEPTH_LOG2+1:2] : word_idx_q;
   assign fault_now = (state_q == IDLE) ? addr_fault(i_addr_in, DEPTH_LOG2) : pend_fault_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rd_en   = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (WAIT_CYCLES == 0) begin
                  state_d = RESP;
                  rd_en   = 1'b1;
               end else begin
                  state_d = WAIT;
                  cnt_d   = WAIT_LOAD;
               end
            end
         end
         WAIT: begin
            if (flush_in) begin
               state_d = IDLE;
            end else if (cnt_q == 4'd0) begin
               state_d = RESP;
               rd_en   = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            if (flush_in || instr_ready_in) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q      <= IDLE;
         cnt_q        <= 4'd0;
         word_idx_q   <= '0;
         pend_fault_q <= 1'b0;
         fault_q      <= 1'b0;
         nop_sel_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            word_idx_q   <= i_addr_in[DEPTH_LOG2+1:2];
            pend_fault_q <= addr_fault(i_addr_in, DEPTH_LOG2);
         end
         if (rd_en) begin
            fault_q   <= fault_now;
            nop_sel_q <= fault_now;
         end else if (flush_in && (state_q != IDLE)) begin
            fault_q <= 1'b0;
         end
      end
   end

   // The RAM output register only changes on a RESP-entry edge, so selecting
   // between it and NOP with a registered flag keeps instr_out stable between
   // responses and NOP out of reset.
   assign instr_out       = nop_sel_q ? NOP_INSTR : ram_rd_data;
   assign instr_fault_out = fault_q;
   assign instr_valid_out = (state_q == RESP);

   msrv32_imem_ram #(
      .DEPTH_LOG2(DEPTH_LOG2)
   ) u_ram (
      .clk     (clk_in),
      .wr_en   (wr_en_in),
      .wr_addr (wr_addr_in),
      .wr_data (wr_data_in),
      .rd_en   (rd_en),
      .rd_addr (rd_idx),
      .rd_data (ram_rd_data)
   );

endmodule

// File: tb/tb_msrv32_imem_responder.sv
module tb_msrv32_imem_responder;

   localparam int unsigned DL2 = 10;
   localparam int unsigned WC  = 1;
   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef struct {
      logic [31:0] data;
      logic        fault;
      int          acc_cyc;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            req_valid = 1'b0;
   logic            req_ready;
   logic [31:0]     i_addr = '0;
   logic            flush = 1'b0;
   logic [31:0]     instr;
   logic            instr_valid;
   logic            instr_ready = 1'b1;
   logic            instr_fault;
   logic            wr_en = 1'b0;
   logic [DL2-1:0]  wr_addr = '0;
   logic [31:0]     wr_data = '0;

   int   n_checks = 0;
   int   n_pass   = 0;
   int   cyc      = 0;
   int   rdy_mode = 0;    // 0: always ready, 1: random, 2: never ready
   bit   head_seen = 0;
   exp_t exp_q[$];
   logic [31:0] model_mem [int];

   msrv32_imem_responder #(
      .DEPTH_LOG2(DL2), .WAIT_CYCLES(WC), .NOP_INSTR(NOP)
   ) dut (
      .clk_in(clk), .rst_in(rst_n),
      .req_valid_in(req_valid), .req_ready_out(req_ready), .i_addr_in(i_addr),
      .flush_in(flush),
      .instr_out(instr), .instr_valid_out(instr_valid),
      .instr_ready_in(instr_ready), .instr_fault_out(instr_fault),
      .wr_en_in(wr_en), .wr_addr_in(wr_addr), .wr_data_in(wr_data)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      if (rdy_mode == 1)      instr_ready = 1'($urandom_range(0, 1));
      else if (rdy_mode == 0) instr_ready = 1'b1;
      else                    instr_ready = 1'b0;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
   endtask

   // Reference: a fetch returns the stored word unless the byte address is
   // misaligned or at/above 4 << DL2 bytes, in which case NOP with fault.
   function automatic exp_t model_fetch(input logic [31:0] a);
      exp_t e;
      bit bad;
      int idx;
      bad = (a % 4 != 0) || (a >= (32'd4 << DL2));
      idx = int'(a / 4) % (1 << DL2);
      e.fault = bad;
      if (bad) e.data = NOP;
      else e.data = model_mem.exists(idx) ? model_mem[idx] : 32'hx;
      e.acc_cyc = 0;
      return e;
   endfunction

   // Monitor: compares every cycle the response is presented (covers hold
   // stability) and the first-presentation latency; pops on delivery.
   always @(negedge clk) begin
      if (rst_n && instr_valid) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_valid", 32'(instr_valid), 32'd0);
         end else begin
            if (!head_seen) begin
               chk("latency", cyc, exp_q[0].acc_cyc + 1 + WC);
               head_seen = 1;
            end
            chk("instr", instr, exp_q[0].data);
            chk("fault", 32'(instr_fault), 32'(exp_q[0].fault));
            if (instr_ready && !flush) begin
               void'(exp_q.pop_front());
               head_seen = 0;
            end
         end
      end
   end

   task automatic preload(input int idx, input logic [31:0] d);
      @(posedge clk); #1;
      wr_en = 1'b1; wr_addr = DL2'(idx); wr_data = d;
      @(posedge clk); #1;
      wr_en = 1'b0;
      model_mem[idx] = d;
   endtask

   // Issue one fetch; returns the cycle in which it was accepted (-1 if never).
   task automatic fetch(input logic [31:0] a, output int acc);
      exp_t e;
      acc = -1;
      @(posedge clk); #1;
      req_valid = 1'b1; i_addr = a;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (req_ready) begin
            acc = cyc;
            e = model_fetch(a);
            e.acc_cyc = cyc;
            exp_q.push_back(e);
            break;
         end
      end
      if (acc < 0) chk("accept_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int i;
      for (i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
      if (exp_q.size() != 0) begin
         chk("drain_timeout", 32'(exp_q.size()), 32'd0);
         exp_q.delete();
         head_seen = 0;
      end
   endtask

   task automatic wait_valid();
      int i;
      for (i = 0; i < 50; i++) begin
         @(negedge clk);
         if (instr_valid) break;
      end
      if (!instr_valid) chk("valid_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      int acc;
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int acc;
      logic [31:0] a;
      // Reset state
      repeat (3) @(posedge clk);
      #2;
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_fault", 32'(instr_fault), 32'd0);
      chk("rst_instr", instr, NOP);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_ready", 32'(req_ready), 32'd1);

      // Basic fetch with latency and ready returning at N+3
      preload(3, 32'h00A0_0093);
      fetch(32'h0000_000C, acc);
      while (cyc < acc + 3) @(negedge clk);
      chk("ready_again", 32'(req_ready), 32'd1);
      wait_drain();

      // Fault cases
      fetch(32'h0000_0006, acc);
      wait_drain();
      fetch(32'h0000_1000, acc);
      wait_drain();

      // Hold for 5 cycles under backpressure
      rdy_mode = 2;
      fetch(32'h0000_000C, acc);
      wait_valid();
      for (int i = 0; i < 5; i++) begin
         chk("hold_valid", 32'(instr_valid), 32'd1);
         chk("hold_instr", instr, 32'h00A0_0093);
         @(negedge clk);
      end
      rdy_mode = 0;
      @(negedge clk);   // handshake cycle
      @(negedge clk);
      chk("after_hs_valid", 32'(instr_valid), 32'd0);
      chk("after_hs_ready", 32'(req_ready), 32'd1);
      wait_drain();

      // Flush while waiting
      fetch(32'h0000_000C, acc);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      exp_q.delete(); head_seen = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("flush_wait_valid", 32'(instr_valid), 32'd0);
      end
      chk("flush_wait_idle", 32'(req_ready), 32'd1);

      // Flush in idle blocks acceptance
      @(posedge clk); #1;
      flush = 1'b1; req_valid = 1'b1; i_addr = 32'h0000_000C;
      @(negedge clk);
      chk("flush_idle_ready", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
      flush = 1'b0; req_valid = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("flush_idle_noacc", 32'(instr_valid), 32'd0);
      end

      // Flush while presenting, with ready high in the same cycle
      rdy_mode = 2;
      fetch(32'h0000_000C, acc);
      wait_valid();
      @(posedge clk); #1;
      flush = 1'b1; rdy_mode = 0; instr_ready = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      exp_q.delete(); head_seen = 0;
      @(negedge clk);
      chk("flush_resp_valid", 32'(instr_valid), 32'd0);
      chk("flush_resp_fault", 32'(instr_fault), 32'd0);

      // Write on the RESP-entry edge returns old data
      fetch(32'h0000_000C, acc);        // returns at posedge+1 of WAIT cycle
      wr_en = 1'b1; wr_addr = DL2'(3); wr_data = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      wr_en = 1'b0;
      model_mem[3] = 32'hDEAD_BEEF;
      wait_drain();
      fetch(32'h0000_000C, acc);
      wait_drain();

      // Asynchronous reset during a presented response
      rdy_mode = 2;
      fetch(32'h0000_000C, acc);
      wait_valid();
      #2;
      rst_n = 1'b0;
      exp_q.delete(); head_seen = 0;
      #1;
      chk("async_rst_valid", 32'(instr_valid), 32'd0);
      rdy_mode = 0;
      @(posedge clk); #3;
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", 32'(req_ready), 32'd1);
      chk("post_rst_instr", instr, NOP);

      // Randomised traffic: preloads between fetches, random ready
      for (int i = 0; i < 16; i++) preload(i, $urandom);
      rdy_mode = 1;
      for (int i = 0; i < 60; i++) begin
         case ($urandom_range(0, 5))
            0: begin
               wait_drain();
               preload($urandom_range(0, 15), $urandom);
            end
            1: fetch(32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(1, 3)), acc);
            2: fetch((32'd4 << DL2) + 32'($urandom_range(0, 255)) * 4, acc);
            default: begin
               a = 32'($urandom_range(0, 15)) * 4;
               wait_drain();
               fetch(a, acc);
            end
         endcase
         wait_drain();
      end
      rdy_mode = 0;
      wait_drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
